// File: rtl/qdec_pkg.sv
// Shared types and the transition classifier for the quadrature decoder.
// The optional glitch filter is enabled by defining QDEC_FILTER_EN.
package qdec_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic [1:0] {
        PH_00 = 2'b00,
        PH_01 = 2'b01,
        PH_11 = 2'b11,
        PH_10 = 2'b10
    } phase_t;

    typedef enum logic [1:0] {
        NONE    = 2'b00,
        UP      = 2'b01,
        DOWN    = 2'b10,
        ILLEGAL = 2'b11
    } trans_t;

    // Gray-code walk: a single-bit change is a step, and its direction is
    // fixed by where it lands relative to the up sequence 00-01-11-10.
    function automatic trans_t classify(input phase_t prev, input phase_t cur);
        trans_t t;
        if (prev == cur) begin
            t = NONE;
        end else if ((prev ^ cur) == 2'b11) begin
            t = ILLEGAL;
        end else begin
            case (prev)
                PH_00:   t = (cur == PH_01) ? UP : DOWN;
                PH_01:   t = (cur == PH_11) ? UP : DOWN;
                PH_11:   t = (cur == PH_10) ? UP : DOWN;
                PH_10:   t = (cur == PH_00) ? UP : DOWN;
                default: t = NONE;
            endcase
        end
        return t;
    endfunction

endpackage

// File: rtl/qdec_sync_filter.sv
// Synchroniser chain for one asynchronous encoder phase, with an optional
// glitch filter enabled by defining QDEC_FILTER_EN.
module qdec_sync_filter
    import qdec_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic d_in,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_r;

    // Metastability chain; only the last stage is consumed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], d_in};
        end
    end

`ifdef QDEC_FILTER_EN
    localparam int CW = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

    logic          filt_r;
    logic [CW-1:0] cnt_r;

    // Accept a new level only after it has differed for FILTER_CYCLES clocks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_r <= 1'b0;
            cnt_r  <= {CW{1'b0}};
        end else if (sync_r[SYNC_STAGES-1] == filt_r) begin
            cnt_r  <= {CW{1'b0}};
        end else if (cnt_r == LAST) begin
            filt_r <= sync_r[SYNC_STAGES-1];
            cnt_r  <= {CW{1'b0}};
        end else begin
            cnt_r  <= cnt_r + CW'(1);
        end
    end

    assign q = filt_r;
`else
    assign q = sync_r[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/quad_decoder4.sv
// Quadrature decoder: synchronised A/B phases drive a wrapping position count.
// Defining QDEC_FILTER_EN inserts a per-phase glitch filter ahead of the decoder.
module quad_decoder4
    import qdec_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             err
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             a_s;
    logic             b_s;
    logic [1:0]       ab_s;
    trans_t           trans_s;
    logic [1:0]       prev_ab_r;
    logic [WIDTH-1:0] count_r;
    logic             dir_r;
    logic             step_r;
    logic             err_r;

    qdec_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_sync_a (
        .clk(clk), .reset(reset), .d_in(a_in), .q(a_s)
    );

    qdec_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_sync_b (
        .clk(clk), .reset(reset), .d_in(b_in), .q(b_s)
    );

    assign ab_s    = {a_s, b_s};
    assign trans_s = classify(phase_t'(prev_ab_r), phase_t'(ab_s));

    // Decoder state: clr wins over any step or illegal transition this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_ab_r <= 2'b00;
            count_r   <= {WIDTH{1'b0}};
            dir_r     <= DIR_UP;
            step_r    <= 1'b0;
            err_r     <= 1'b0;
        end else if (clr) begin
            prev_ab_r <= ab_s;
            count_r   <= {WIDTH{1'b0}};
            step_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            prev_ab_r <= ab_s;
            case (trans_s)
                UP: begin
                    count_r <= count_r + ONE;
                    dir_r   <= DIR_UP;
                    step_r  <= 1'b1;
                end
                DOWN: begin
                    count_r <= count_r - ONE;
                    dir_r   <= DIR_DOWN;
                    step_r  <= 1'b1;
                end
                ILLEGAL: begin
                    err_r  <= 1'b1;
                    step_r <= 1'b0;
                end
                default: begin
                    step_r <= 1'b0;
                end
            endcase
        end
    end

    assign count = count_r;
    assign dir   = dir_r;
    assign step  = step_r;
    assign err   = err_r;

endmodule

// File: tb/tb_quad_decoder4.sv
// Directed bench for quad_decoder4 with a step scoreboard; the filter test
// runs only when QDEC_FILTER_EN is defined.
module tb_quad_decoder4;

    localparam int WIDTH         = 4;
    localparam int SYNC_STAGES   = 2;
    localparam int FILTER_CYCLES = 3;
`ifdef QDEC_FILTER_EN
    localparam int LAT = SYNC_STAGES + FILTER_CYCLES + 1;
`else
    localparam int LAT = SYNC_STAGES + 1;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             a_in;
    logic             b_in;
    logic             clr;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             step;
    logic             err;

    typedef struct packed {
        logic [WIDTH-1:0] cnt;
        logic             dir;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   nsteps   = 0;
    int   npushed  = 0;

    logic [1:0]       m_prev;
    logic [WIDTH-1:0] m_cnt;
    logic             m_dir;
    logic             m_err;

    quad_decoder4 #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) dut (
        .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .clr(clr),
        .count(count), .dir(dir), .step(step), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] up_next(input logic [1:0] p);
        case (p)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // Reference decoder: pushes the expected count/dir for every step it predicts.
    task automatic model(input logic [1:0] cur);
        if (cur != m_prev) begin
            if (cur == up_next(m_prev)) begin
                m_cnt = m_cnt + 4'd1;
                m_dir = 1'b0;
                sb.push_back({m_cnt, 1'b0});
                npushed++;
            end else if (m_prev == up_next(cur)) begin
                m_cnt = m_cnt - 4'd1;
                m_dir = 1'b1;
                sb.push_back({m_cnt, 1'b1});
                npushed++;
            end else begin
                m_err = 1'b1;
            end
        end
        m_prev = cur;
    endtask

    task automatic drive(input logic a, input logic b, input int n);
        @(negedge clk);
        a_in = a;
        b_in = b;
        model({a, b});
        repeat (n) @(negedge clk);
    endtask

    task automatic clear();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr   = 1'b0;
        m_cnt = 4'd0;
        m_err = 1'b0;
    endtask

    // Every step pulse must match the oldest predicted step.
    always @(negedge clk) begin
        if (reset === 1'b1 && step === 1'b1) begin
            nsteps++;
            check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("sb_count", 32'(count), 32'(e.cnt));
                check("sb_dir", 32'(dir), 32'(e.dir));
            end
        end
    end

    initial begin
        reset = 1'b0; a_in = 1'b0; b_in = 1'b0; clr = 1'b0;
        m_prev = 2'b00; m_cnt = 4'd0; m_dir = 1'b0; m_err = 1'b0;
        #12;
        check("rst_count", 32'(count), 32'd0);
        check("rst_dir", 32'(dir), 32'd0);
        check("rst_step", 32'(step), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 10);
            drive(1'b1, 1'b1, 10);
            drive(1'b1, 1'b0, 10);
            drive(1'b0, 1'b0, 10);
        end
        check("up20_count", 32'(count), 32'd4);
        check("up20_dir", 32'(dir), 32'd0);
        check("up20_err", 32'(err), 32'd0);
        check("up20_steps", 32'(nsteps), 32'd20);

        clear();
        check("clr_count", 32'(count), 32'd0);

        // Down step 00->10 with exact latency.
        @(negedge clk);
        a_in = 1'b1; b_in = 1'b0;
        model(2'b10);
        repeat (LAT - 1) @(posedge clk);
        #1;
        check("down_early_step", 32'(step), 32'd0);
        check("down_early_count", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        check("down_step", 32'(step), 32'd1);
        check("down_wrap_count", 32'(count), 32'd15);
        check("down_dir", 32'(dir), 32'd1);
        repeat (8) @(negedge clk);
        drive(1'b0, 1'b0, 10);

        // Illegal jump then legal steps; err sticks until clr.
        drive(1'b1, 1'b1, 10);
        check("ill_err", 32'(err), 32'd1);
        check("ill_count", 32'(count), 32'd0);
        drive(1'b1, 1'b0, 10);
        drive(1'b0, 1'b0, 10);
        check("ill_after_count", 32'(count), 32'd2);
        check("ill_after_err", 32'(err), 32'd1);
        clear();
        check("ill_clr_count", 32'(count), 32'd0);
        check("ill_clr_err", 32'(err), 32'd0);

        // clr coincides with a legal up transition reaching the decoder.
        drive(1'b0, 1'b1, 10);
        drive(1'b1, 1'b1, 10);
        check("pre_coll_count", 32'(count), 32'd2);
        @(negedge clk);
        a_in = 1'b1; b_in = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("coll_count", 32'(count), 32'd0);
        check("coll_step", 32'(step), 32'd0);
        @(posedge clk);
        #1;
        check("coll_next_step", 32'(step), 32'd0);
        check("coll_next_count", 32'(count), 32'd0);
        m_prev = 2'b10; m_cnt = 4'd0; m_err = 1'b0;
        repeat (8) @(negedge clk);
        drive(1'b0, 1'b0, 10);
        check("post_coll_count", 32'(count), 32'd1);

        // Reach count 7 going down with err set, then async reset.
        drive(1'b0, 1'b1, 10);
        drive(1'b1, 1'b1, 10);
        drive(1'b1, 1'b0, 10);
        drive(1'b0, 1'b0, 10);
        drive(1'b0, 1'b1, 10);
        drive(1'b1, 1'b1, 10);
        drive(1'b1, 1'b0, 10);
        drive(1'b1, 1'b1, 10);
        drive(1'b0, 1'b0, 10);
        check("pre_rst_count", 32'(count), 32'd7);
        check("pre_rst_dir", 32'(dir), 32'd1);
        check("pre_rst_err", 32'(err), 32'd1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_count", 32'(count), 32'd0);
        check("async_dir", 32'(dir), 32'd0);
        check("async_err", 32'(err), 32'd0);
        check("async_step", 32'(step), 32'd0);
        a_in = 1'b0; b_in = 1'b1;
        #20;
        @(negedge clk);
        reset = 1'b1;
        m_prev = 2'b00; m_cnt = 4'd0; m_dir = 1'b0; m_err = 1'b0;
        model(2'b01);
        repeat (10) @(negedge clk);
        check("post_rst_count", 32'(count), 32'd1);
        check("post_rst_dir", 32'(dir), 32'd0);

`ifdef QDEC_FILTER_EN
        // A 2-clk glitch on a_in must not step.
        @(negedge clk);
        a_in = 1'b1;
        repeat (2) @(negedge clk);
        a_in = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_count", 32'(count), 32'd1);
        @(negedge clk);
        a_in = 1'b1;
        model(2'b11);
        repeat (LAT - 1) @(posedge clk);
        #1;
        check("filt_early_step", 32'(step), 32'd0);
        @(posedge clk);
        #1;
        check("filt_step", 32'(step), 32'd1);
        check("filt_count", 32'(count), 32'd2);
        repeat (8) @(negedge clk);
`endif

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("step_total", 32'(nsteps), 32'(npushed));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/quad_decoder4.md
Name: quad_decoder4

Overview:
- Quadrature decoder. It converts the two-phase A/B signals from an incremental encoder into up/down steps and drives a wrap-around position counter.
- Direction polarity matches the team's up/down counters: dir=0 is up, dir=1 is down. Count and dir can therefore feed existing counter-based logic directly.
- Sits at the chip boundary. The A/B inputs are asynchronous and are synchronised internally.

Parameters:
- WIDTH, 4, position counter width in bits.
- SYNC_STAGES, 2, number of synchroniser flops per phase input (minimum 2).
- FILTER_CYCLES, 3, stable-cycle count the glitch filter requires (used only with the optional feature).

Ports:
- clk  input  1  rising-edge system clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- a_in  input  1  encoder phase A, asynchronous.
- b_in  input  1  encoder phase B, asynchronous.
- clr  input  1  synchronous clear of count and err, active high.
- count  output  WIDTH  position count.
- dir  output  1  direction of the last valid step (0 = up, 1 = down).
- step  output  1  one-cycle pulse on each accepted step.
- err  output  1  sticky illegal-transition flag.

Behaviour:
- Reset (reset=0, asynchronous): count=0, dir=0, step=0, err=0, all synchroniser flops=0, prev_ab=2'b00.
- Synchronisation: a_in and b_in each pass through SYNC_STAGES flops, giving ab_s = {a_s, b_s}.
- prev_ab register: holds the last accepted phase state and is updated every cycle from ab_s.
- Up sequence (ab): 00->01->11->10->00. Each such transition sets count<=count+1, dir<=0, step<=1.
- Down sequence: the reverse order. Each such transition sets count<=count-1, dir<=1, step<=1.
- Width and wrap: count is modulo 2^WIDTH. Up from all-ones wraps to 0; down from 0 wraps to all-ones. No saturation and no carry output.
- No change (ab_s == prev_ab): step=0; count and dir hold.
- Illegal transition (both bits change: 00<->11, 01<->10): err<=1 (sticky), count and dir unchanged, step=0, prev_ab still takes ab_s.
- Latency: a settled input edge produces its count/step update on the (SYNC_STAGES+1)th rising clk edge. Default is 3 edges.
- step: registered, high for exactly one cycle per step. Maximum rate is one step per clk.
- clr=1: count<=0, err<=0, step<=0, dir holds, prev_ab<=ab_s (no step generated). clr has priority over a simultaneous step or illegal transition.
- Reset mid-operation: all state returns to the reset values immediately. After release, the first ab_s sample that differs from 00 is decoded as a normal transition from 00 (it may step or set err).

Optional Feature:
- Macro: QDEC_FILTER_EN.
- Defined: a per-phase glitch filter sits between the synchroniser and the decoder. A phase's filtered value changes only after its synchronised value differs from the current filtered value for FILTER_CYCLES consecutive clks. Any return to the filtered value restarts the counter.
  - Each filter counter is $clog2(FILTER_CYCLES+1) bits wide and resets to 0.
  - Latency becomes SYNC_STAGES+FILTER_CYCLES+1 edges.
  - Pulses shorter than FILTER_CYCLES are ignored.
- Not defined: no filter logic is present, latency is as stated above, and FILTER_CYCLES is unused.

Decomposition:
- Package qdec_pkg:
  - DIR_UP=1'b0, DIR_DOWN=1'b1.
  - 2-bit phase-state typedef with constants PH_00, PH_01, PH_11, PH_10.
  - Function classify(prev, cur) returning NONE/UP/DOWN/ILLEGAL.
- Sub-module qdec_sync_filter: one instance per phase, containing the synchroniser chain plus the optional filter. The top module holds the decoder, counter and flags.

Test Plan:
- Reset then 5 up cycles (00,01,11,10,00 repeated, 10 clks per phase) -> count=20 mod 16=4, dir=0, 20 single-cycle step pulses, err=0.
- From count=0, one down step (00->10) -> count=15 (wrap), dir=1, step pulses once, exactly 3 clks after b_in... a_in rises.
- Jump 00->11 (a_in and b_in toggle together) -> err=1, count unchanged. Subsequent legal steps still count, err stays 1 until clr=1, then count=0 and err=0.
- clr asserted on the same cycle a legal up transition reaches the decoder -> count=0, step=0, no increment on the following cycle.
- reset pulsed low mid-sequence at count=7 -> count=0, dir=0, err=0 immediately without waiting for clk. After release, inputs at 01 -> count=1.
- With QDEC_FILTER_EN defined: a 2-clk glitch on a_in -> no step. A 3-clk-stable change -> one step, with latency SYNC_STAGES+FILTER_CYCLES+1=6 edges.
